// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-control bundle between the core datapath and the stall/flush sequencer.
// master: datapath side (drives hazard sources); slave: the sequencer.
interface pipeline_hazard_controller_if #(
    parameter int unsigned StallCntW = 32
);
    logic [4:0]           id_rs1;
    logic [4:0]           id_rs2;
    logic                 id_uses_rs1;
    logic                 id_uses_rs2;
    logic                 ex_mem_read;
    logic [4:0]           ex_rd;
    logic                 ex_redirect;
    logic                 imem_valid;
    logic                 md_start;
    logic                 md_done;
    logic                 pc_enable;
    logic                 if_id_enable;
    logic                 if_id_flush;
    logic                 id_ex_enable;
    logic                 id_ex_flush;
    logic                 ex_mem_flush;
    logic                 fetch_timeout;
    logic [StallCntW-1:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
               ex_redirect, imem_valid, md_start, md_done,
        input  pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
               ex_mem_flush, fetch_timeout, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
               ex_redirect, imem_valid, md_start, md_done,
        output pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
               ex_mem_flush, fetch_timeout, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage core: load-use, redirect, imem wait and
// multi-cycle mul/div handling, plus a fetch watchdog and saturating stall counter.
module pipeline_hazard_controller #(
    parameter int unsigned MAX_FETCH_WAIT = 16,
    parameter int unsigned STALL_CNT_W    = 32
) (
    input logic                            clk,
    input logic                            reset,
    pipeline_hazard_controller_if.slave    hz_io
);
    localparam int unsigned WdW = $clog2(MAX_FETCH_WAIT + 1);
    localparam logic [WdW-1:0] WdMax = WdW'(MAX_FETCH_WAIT);

    typedef enum logic [1:0] {StRun, StFetchWait, StMdBusy} state_e;

    state_e                 state_q, state_d;
    logic [WdW-1:0]         wd_q, wd_d;
    logic                   ft_q, ft_d;
    logic [STALL_CNT_W-1:0] stall_q;

    logic load_use;
    logic pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_fl;

    assign load_use = hz_io.ex_mem_read && (hz_io.ex_rd != 5'd0) &&
                      ((hz_io.id_uses_rs1 && (hz_io.id_rs1 == hz_io.ex_rd)) ||
                       (hz_io.id_uses_rs2 && (hz_io.id_rs2 == hz_io.ex_rd)));

    always_comb begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        ifid_fl  = 1'b0;
        idex_en  = 1'b1;
        idex_fl  = 1'b0;
        exmem_fl = 1'b0;
        state_d  = state_q;
        wd_d     = wd_q;

        unique case (state_q)
            StRun, StFetchWait: begin
                if (hz_io.ex_redirect) begin
                    ifid_fl = 1'b1;
                    idex_fl = 1'b1;
                    state_d = StRun;
                    wd_d    = '0;
                end else if (hz_io.md_start) begin
                    wd_d = '0;
                    if (!hz_io.md_done) begin
                        pc_en    = 1'b0;
                        ifid_en  = 1'b0;
                        idex_en  = 1'b0;
                        exmem_fl = 1'b1;
                        state_d  = StMdBusy;
                    end else begin
                        state_d = StRun;
                    end
                end else if (load_use) begin
                    // One bubble only: the load leaves EX on this edge.
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    idex_fl = 1'b1;
                end else if (!hz_io.imem_valid) begin
                    pc_en   = 1'b0;
                    ifid_fl = 1'b1;
                    state_d = StFetchWait;
                    wd_d    = (wd_q == WdMax) ? wd_q : wd_q + 1'b1;
                end else begin
                    state_d = StRun;
                    wd_d    = '0;
                end
            end
            StMdBusy: begin
                wd_d = '0;
                if (hz_io.md_done) begin
                    state_d = StRun;
                end else begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_fl = 1'b1;
                end
            end
            default: begin
                state_d = StRun;
                wd_d    = '0;
            end
        endcase

        if (reset) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            ifid_fl  = 1'b1;
            idex_fl  = 1'b1;
            exmem_fl = 1'b1;
        end
    end

    assign ft_d = ft_q || (wd_d == WdMax);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
            wd_q    <= '0;
            ft_q    <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            ft_q    <= ft_d;
            if (!pc_en && !(&stall_q)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign hz_io.pc_enable     = pc_en;
    assign hz_io.if_id_enable  = ifid_en;
    assign hz_io.if_id_flush   = ifid_fl;
    assign hz_io.id_ex_enable  = idex_en;
    assign hz_io.id_ex_flush   = idex_fl;
    assign hz_io.ex_mem_flush  = exmem_fl;
    assign hz_io.fetch_timeout = ft_q;
    assign hz_io.stall_cycles  = stall_q;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: directed vectors push expected controls/counters; a negedge
// monitor pops and compares against a 32-bit and a 4-bit-counter instance.
module tb_pipeline_hazard_controller;
    logic clk;
    logic reset;

    pipeline_hazard_controller_if #(.StallCntW(32)) hz ();
    pipeline_hazard_controller_if #(.StallCntW(4))  hz4 ();

    pipeline_hazard_controller #(.MAX_FETCH_WAIT(16), .STALL_CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .hz_io (hz)
    );

    pipeline_hazard_controller #(.MAX_FETCH_WAIT(16), .STALL_CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .hz_io (hz4)
    );

    assign hz4.id_rs1      = hz.id_rs1;
    assign hz4.id_rs2      = hz.id_rs2;
    assign hz4.id_uses_rs1 = hz.id_uses_rs1;
    assign hz4.id_uses_rs2 = hz.id_uses_rs2;
    assign hz4.ex_mem_read = hz.ex_mem_read;
    assign hz4.ex_rd       = hz.ex_rd;
    assign hz4.ex_redirect = hz.ex_redirect;
    assign hz4.imem_valid  = hz.imem_valid;
    assign hz4.md_start    = hz.md_start;
    assign hz4.md_done     = hz.md_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_flush}
    localparam logic [5:0] CDef    = 6'b110100;
    localparam logic [5:0] CReset  = 6'b001011;
    localparam logic [5:0] CFreeze = 6'b000001;
    localparam logic [5:0] CLoadU  = 6'b000110;
    localparam logic [5:0] CRedir  = 6'b111110;
    localparam logic [5:0] CFWait  = 6'b011100;

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       redir;
        logic       iv;
        logic       ms;
        logic       md;
    } stim_t;

    typedef struct {
        logic [5:0]  ctrl;
        logic        ft;
        logic [31:0] sc;
        logic [3:0]  sc4;
        string       nm;
    } exp_t;

    exp_t        sb_q[$];
    stim_t       s;
    logic [31:0] exp_stall;
    logic [3:0]  exp_stall4;
    int          checks;
    int          errors;

    function automatic stim_t idle();
        stim_t t;
        t.rst = 1'b0; t.rs1 = 5'd0; t.rs2 = 5'd0; t.u1 = 1'b0; t.u2 = 1'b0;
        t.mr = 1'b0; t.rd = 5'd0; t.redir = 1'b0; t.iv = 1'b1; t.ms = 1'b0;
        t.md = 1'b0;
        return t;
    endfunction

    task automatic step(input logic [5:0] ctrl, input logic ft, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset          = s.rst;
        hz.id_rs1      = s.rs1;
        hz.id_rs2      = s.rs2;
        hz.id_uses_rs1 = s.u1;
        hz.id_uses_rs2 = s.u2;
        hz.ex_mem_read = s.mr;
        hz.ex_rd       = s.rd;
        hz.ex_redirect = s.redir;
        hz.imem_valid  = s.iv;
        hz.md_start    = s.ms;
        hz.md_done     = s.md;
        e.ctrl = ctrl;
        e.ft   = ft;
        e.sc   = exp_stall;
        e.sc4  = exp_stall4;
        e.nm   = nm;
        sb_q.push_back(e);
        // Counters are registered: this cycle's stall shows up next sample.
        if (s.rst) begin
            exp_stall  = '0;
            exp_stall4 = '0;
        end else if (!ctrl[5]) begin
            if (exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 1;
            if (exp_stall4 != 4'hF) exp_stall4 = exp_stall4 + 1;
        end
    endtask

    // Monitor: pops one expectation per cycle the driver issued.
    initial begin
        exp_t e;
        logic [5:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                act = {hz.pc_enable, hz.if_id_enable, hz.if_id_flush, hz.id_ex_enable,
                       hz.id_ex_flush, hz.ex_mem_flush};
                checks++;
                if (act !== e.ctrl || hz.fetch_timeout !== e.ft ||
                    hz.stall_cycles !== e.sc || hz4.stall_cycles !== e.sc4) begin
                    errors++;
                    $display("FAIL %s: got ctrl=%b ft=%b sc=%0d sc4=%0d, want ctrl=%b ft=%b sc=%0d sc4=%0d",
                             e.nm, act, hz.fetch_timeout, hz.stall_cycles, hz4.stall_cycles,
                             e.ctrl, e.ft, e.sc, e.sc4);
                end
            end
        end
    end

    initial begin
        checks     = 0;
        errors     = 0;
        exp_stall  = '0;
        exp_stall4 = '0;
        s          = idle();
        s.rst      = 1'b1;
        reset      = 1'b1;
        hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_uses_rs1 = 0; hz.id_uses_rs2 = 0;
        hz.ex_mem_read = 0; hz.ex_rd = '0; hz.ex_redirect = 0; hz.imem_valid = 1;
        hz.md_start = 0; hz.md_done = 0;
        repeat (2) @(posedge clk);

        step(CReset, 1'b0, "reset_state");
        s = idle();
        step(CDef, 1'b0, "default_run");

        // Load-use on rs2, then one bubble only
        s.mr = 1; s.rd = 5'd5; s.rs2 = 5'd5; s.u2 = 1;
        step(CLoadU, 1'b0, "lu_rs2");
        s = idle();
        step(CDef, 1'b0, "lu_after");
        s.mr = 1; s.rd = 5'd0; s.rs2 = 5'd0; s.u2 = 1;
        step(CDef, 1'b0, "lu_rd0");
        s = idle(); s.mr = 1; s.rd = 5'd7; s.rs1 = 5'd7; s.u1 = 1;
        step(CLoadU, 1'b0, "lu_rs1");
        s.u1 = 0;
        step(CDef, 1'b0, "lu_rs1_unused");

        // Redirect beats load-use
        s = idle(); s.mr = 1; s.rd = 5'd5; s.rs2 = 5'd5; s.u2 = 1; s.redir = 1;
        step(CRedir, 1'b0, "redir_over_lu");
        s = idle();
        step(CDef, 1'b0, "redir_no_stall");

        // Multi-cycle op t0..t4; redirect/load-use ignored while busy
        s.ms = 1;
        step(CFreeze, 1'b0, "md_t0");
        step(CFreeze, 1'b0, "md_t1");
        s.redir = 1; s.mr = 1; s.rd = 5'd3; s.rs1 = 5'd3; s.u1 = 1;
        step(CFreeze, 1'b0, "md_t2_ignore");
        s = idle(); s.ms = 1;
        step(CFreeze, 1'b0, "md_t3");
        s.ms = 0; s.md = 1;
        step(CDef, 1'b0, "md_t4_done");
        s = idle(); s.ms = 1; s.md = 1;
        step(CDef, 1'b0, "md_one_cycle");
        s = idle();
        step(CDef, 1'b0, "md_count");

        // Reset held 3 cycles mid mul/div
        s.ms = 1;
        step(CFreeze, 1'b0, "md_pre_reset");
        s.rst = 1;
        for (int i = 0; i < 3; i++) step(CReset, 1'b0, "reset_mid_md");
        s = idle();
        step(CDef, 1'b0, "after_reset_run");

        // Fetch wait: watchdog trips after 16 low cycles; 20 stalls saturate 4-bit counter
        s.iv = 0;
        for (int k = 1; k <= 20; k++) step(CFWait, (k >= 17), "fetch_wait");
        s = idle();
        step(CDef, 1'b1, "fetch_back");
        step(CDef, 1'b1, "fetch_sticky");
        s.rst = 1;
        step(CReset, 1'b1, "reset_ft");
        s = idle();
        step(CDef, 1'b0, "ft_cleared");

        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
